sram_mem_controller: RTL and testbench

- Multi-cycle controller between the pipeline's memory stage and an off-chip 16-bit asynchronous SRAM.
- Accepts one 32-bit load or store per request, splits it into two 16-bit SRAM phases (low half first), and holds `ready` low so the hazard/freeze logic stalls the pipeline until the access completes.
- Replaces the single-cycle data memory behind the memory stage.

---
 rtl/sram_mem_controller_pkg.sv | 26 ++
 rtl/sram_phase_timer.sv | 29 ++
 rtl/sram_mem_controller.sv | 134 +++++++++++++
 tb/tb_sram_mem_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the 16-bit asynchronous SRAM controller behind the memory stage.
// Also read by the hazard unit for the freeze polarity of `ready`.
package sram_mem_controller_pkg;

    localparam int SRAM_DW = 16;

    // Level of `ready` at which the hazard unit freezes the pipeline.
    localparam logic READY_FREEZE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } ctrl_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

    function automatic logic [SRAM_DW-1:0] select_half(input logic [31:0] word, input logic half);
        return half ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Counts the cycles of one SRAM phase and flags its last cycle.
// The count restarts on its own after the last cycle, so consecutive phases need no explicit clear.
module sram_phase_timer #(
    parameter int PHASE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [3:0] LAST_COUNT = 4'(PHASE_CYCLES - 1);

    logic [3:0] count;

    assign last = enable && (count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || last) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit load/store from the memory stage into two 16-bit SRAM phases (low half first),
// holding `ready` low so the pipeline freezes until the access completes.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int SRAM_AW      = 18,
    parameter int PHASE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    ctrl_state_t        state_q;
    ctrl_state_t        state_d;
    mem_op_t            op_q;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        data_q;
    logic               request;
    logic               in_phase;
    logic               half;
    logic               phase_last;
    logic               unused_address_bits;

    assign request  = rd_en || wr_en;
    assign in_phase = (state_q == LOW) || (state_q == HIGH);
    assign half     = (state_q == HIGH);

    // Byte offset and bits above the SRAM range are deliberately dropped: no alignment or range faults.
    assign unused_address_bits = ^{address[31:SRAM_AW+1], address[1:0]};

    sram_phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (!in_phase),
        .enable(in_phase),
        .last  (phase_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The requester holds its inputs during the freeze, but only the captured copy is used afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q   <= OP_READ;
            word_q <= '0;
            data_q <= '0;
        end else if ((state_q == IDLE) && request) begin
            op_q   <= wr_en ? OP_WRITE : OP_READ;
            word_q <= address[SRAM_AW:2];
            data_q <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            read_data <= '0;
        end else if (in_phase && (op_q == OP_READ) && phase_last) begin
            if (half) begin
                read_data[31:16] <= sram_dq_in;
            end else begin
                read_data[15:0] <= sram_dq_in;
            end
        end
    end

    // The write strobe rises in the last cycle of each phase so address and data are held past it.
    always_comb begin
        state_d     = state_q;
        ready       = READY_FREEZE;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;

        if (in_phase) begin
            sram_addr = {word_q, half};
            if (op_q == OP_WRITE) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = select_half(data_q, half);
                sram_we_n   = phase_last;
            end else begin
                sram_oe_n = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                ready = request ? READY_FREEZE : ~READY_FREEZE;
                if (request) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = ~READY_FREEZE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller: a default build and a PHASE_CYCLES=3 build share one SRAM model.
// Stimulus pushes expected phase cycles and completions; a negedge monitor pops and compares them.
module tb_sram_mem_controller;
    import sram_mem_controller_pkg::*;

    localparam int AW = 18;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   dq;
        logic          we_n;
        logic          oe_n;
        logic          dq_oe;
    } phase_exp_t;

    typedef struct packed {
        logic [7:0]  low_cycles;
        logic [31:0] rd;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          wr_en_a = 0, rd_en_a = 0;
    logic [31:0]   address_a = 0, write_data_a = 0, read_data_a;
    logic          ready_a, dq_oe_a, we_n_a, oe_n_a;
    logic [AW-1:0] sram_addr_a;
    logic [15:0]   dq_out_a, dq_in_a;

    logic          wr_en_b = 0, rd_en_b = 0;
    logic [31:0]   address_b = 0, write_data_b = 0, read_data_b;
    logic          ready_b, dq_oe_b, we_n_b, oe_n_b;
    logic [AW-1:0] sram_addr_b;
    logic [15:0]   dq_out_b, dq_in_b;

    sram_mem_controller #(.SRAM_AW(AW), .PHASE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .rd_en(rd_en_a),
        .address(address_a), .write_data(write_data_a), .read_data(read_data_a),
        .ready(ready_a), .sram_addr(sram_addr_a), .sram_dq_out(dq_out_a),
        .sram_dq_in(dq_in_a), .sram_dq_oe(dq_oe_a), .sram_we_n(we_n_a), .sram_oe_n(oe_n_a)
    );

    sram_mem_controller #(.SRAM_AW(AW), .PHASE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b),
        .address(address_b), .write_data(write_data_b), .read_data(read_data_b),
        .ready(ready_b), .sram_addr(sram_addr_b), .sram_dq_out(dq_out_b),
        .sram_dq_in(dq_in_b), .sram_dq_oe(dq_oe_b), .sram_we_n(we_n_b), .sram_oe_n(oe_n_b)
    );

    logic [15:0] mem [0:4095];
    assign dq_in_a = mem[sram_addr_a[11:0]];
    assign dq_in_b = mem[sram_addr_b[11:0]];

    always @(posedge clk) begin
        if (!we_n_a) mem[sram_addr_a[11:0]] <= dq_out_a;
        if (!we_n_b) mem[sram_addr_b[11:0]] <= dq_out_b;
    end

    logic          sel_b = 1'b0;
    logic          mon_ready, mon_dq_oe, mon_we_n, mon_oe_n;
    logic [AW-1:0] mon_addr;
    logic [15:0]   mon_dq;
    logic [31:0]   mon_rd;
    assign mon_ready = sel_b ? ready_b     : ready_a;
    assign mon_dq_oe = sel_b ? dq_oe_b     : dq_oe_a;
    assign mon_we_n  = sel_b ? we_n_b      : we_n_a;
    assign mon_oe_n  = sel_b ? oe_n_b      : oe_n_a;
    assign mon_addr  = sel_b ? sram_addr_b : sram_addr_a;
    assign mon_dq    = sel_b ? dq_out_b    : dq_out_a;
    assign mon_rd    = sel_b ? read_data_b : read_data_a;

    phase_exp_t phase_q[$];
    done_exp_t  done_q[$];
    int checks = 0;
    int errors = 0;

    // Monitor: every cycle with SRAM activity pops a phase entry; every rising edge of ready pops a completion.
    initial begin
        int         low_run;
        phase_exp_t pe;
        done_exp_t  de;
        low_run = 0;
        forever begin
            @(negedge clk);
            if (!mon_oe_n || mon_dq_oe || !mon_we_n) begin
                checks++;
                if (phase_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_sram_activity t=%0t addr=%h we_n=%b oe_n=%b dq_oe=%b",
                             $time, mon_addr, mon_we_n, mon_oe_n, mon_dq_oe);
                end else begin
                    pe = phase_q.pop_front();
                    if (mon_addr !== pe.addr || mon_we_n !== pe.we_n || mon_oe_n !== pe.oe_n ||
                        mon_dq_oe !== pe.dq_oe || (pe.dq_oe && mon_dq !== pe.dq)) begin
                        errors++;
                        $display("[TB] FAIL phase_cycle t=%0t got addr=%h dq=%h we_n=%b oe_n=%b dq_oe=%b want addr=%h dq=%h we_n=%b oe_n=%b dq_oe=%b",
                                 $time, mon_addr, mon_dq, mon_we_n, mon_oe_n, mon_dq_oe,
                                 pe.addr, pe.dq, pe.we_n, pe.oe_n, pe.dq_oe);
                    end
                end
            end
            if (!rst) begin
                low_run = 0;
            end else if (!mon_ready) begin
                low_run++;
            end else begin
                if (low_run > 0) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_done t=%0t low_cycles=%0d", $time, low_run);
                    end else begin
                        de = done_q.pop_front();
                        if (low_run != int'(de.low_cycles) || mon_rd !== de.rd) begin
                            errors++;
                            $display("[TB] FAIL done_cycle t=%0t got low=%0d read_data=%h want low=%0d read_data=%h",
                                     $time, low_run, mon_rd, de.low_cycles, de.rd);
                        end
                    end
                end
                low_run = 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
        end
    endtask

    task automatic push_txn(input logic wr, input logic [AW-1:0] base, input logic [31:0] data,
                            input int n_cycles, input logic expect_done, input logic [31:0] exp_rd);
        int pc;
        phase_exp_t pe;
        done_exp_t  de;
        pc = sel_b ? 3 : 2;
        for (int i = 0; i < n_cycles; i++) begin
            pe.addr  = base + AW'(i / pc);
            pe.dq    = (i / pc == 1) ? data[31:16] : data[15:0];
            pe.we_n  = wr ? ((i % pc) == pc - 1) : 1'b1;
            pe.oe_n  = wr;
            pe.dq_oe = wr;
            phase_q.push_back(pe);
        end
        if (expect_done) begin
            de.low_cycles = 8'(1 + 2 * pc);
            de.rd         = exp_rd;
            done_q.push_back(de);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
        if (sel_b) begin
            wr_en_b = wr; rd_en_b = rd; address_b = addr; write_data_b = data;
        end else begin
            wr_en_a = wr; rd_en_a = rd; address_a = addr; write_data_a = data;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mon_ready !== 1'b1 && n < 60);
        if (mon_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout got=ready_low want=ready_high_within_60", name);
        end
    endtask

    // Issues one request, waits for DONE, then steps into the following IDLE cycle.
    task automatic apply_stimulus(input string name, input logic wr, input logic rd,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input logic [AW-1:0] base, input logic [31:0] exp_rd,
                                  input logic release_req);
        int pc;
        pc = sel_b ? 3 : 2;
        push_txn(wr, base, data, 2 * pc, 1'b1, exp_rd);
        drive(wr, rd, addr, data);
        wait_done(name);
        @(posedge clk);
        #1;
        if (release_req) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int start_cyc;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ready",     {31'b0, ready_a},     32'h1);
        check_output("reset_read_data", read_data_a,          32'h0);
        check_output("reset_we_n",      {31'b0, we_n_a},      32'h1);
        check_output("reset_oe_n",      {31'b0, oe_n_a},      32'h1);
        check_output("reset_dq_oe",     {31'b0, dq_oe_a},     32'h0);
        check_output("reset_sram_addr", {14'b0, sram_addr_a}, 32'h0);
        check_output("reset_dq_out",    {16'b0, dq_out_a},    32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus("store", 1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 18'h082, 32'h0, 1'b1);
        apply_stimulus("load",  1'b0, 1'b1, 32'h0000_0104, 32'h0,        18'h082, 32'hDEAD_BEEF, 1'b1);
        apply_stimulus("both_high", 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 18'h004, 32'hDEAD_BEEF, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        start_cyc = cyc;
        apply_stimulus("b2b_store", 1'b1, 1'b0, 32'h0000_0200, 32'hA5A5_5A5A, 18'h100, 32'hDEAD_BEEF, 1'b0);
        apply_stimulus("b2b_load",  1'b0, 1'b1, 32'h0000_0200, 32'h0,        18'h100, 32'hA5A5_5A5A, 1'b1);
        check_output("b2b_total_cycles", 32'(cyc - 1 - start_cyc + 1), 32'd12);
        @(posedge clk);
        #1;

        // Store aborted by reset in the first HIGH cycle: only three phase cycles ever appear.
        push_txn(1'b1, 18'h180, 32'h0BAD_F00D, 3, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0300, 32'h0BAD_F00D);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_ready_with_req", {31'b0, ready_a}, 32'h0);
        check_output("abort_we_n",           {31'b0, we_n_a},  32'h1);
        check_output("abort_dq_oe",          {31'b0, dq_oe_a}, 32'h0);
        check_output("abort_read_data",      read_data_a,      32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_output("abort_ready_no_req",   {31'b0, ready_a}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        sel_b = 1'b1;
        apply_stimulus("pc3_store", 1'b1, 1'b0, 32'h0000_0000, 32'hF00D_CAFE, 18'h000, 32'h0, 1'b1);
        apply_stimulus("pc3_load",  1'b0, 1'b1, 32'h0000_0003, 32'h0,        18'h000, 32'hF00D_CAFE, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_output("phase_queue_drained", 32'(phase_q.size()), 32'd0);
        check_output("done_queue_drained",  32'(done_q.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=no_finish want=finish_before_200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
